// File: rtl/stg4ma_pkg.sv
// Shared types, opcode constants and helpers for the stg4ma memory-access stage.
package stg4ma_pkg;

   localparam int DEF_ADDR_W   = 24;
   localparam int DEF_DATA_W   = 24;
   localparam int DEF_OPC_W    = 8;
   localparam int DEF_TGT_GP_W = 4;
   localparam int DEF_TGT_SR_W = 2;

   localparam logic [DEF_OPC_W-1:0] OPC_R_LD    = 8'h10;
   localparam logic [DEF_OPC_W-1:0] OPC_R_ST    = 8'h11;
   localparam logic [DEF_OPC_W-1:0] OPC_I_STi   = 8'h12;
   localparam logic [DEF_OPC_W-1:0] OPC_IS_STis = 8'h13;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } stg4ma_state_e;

   function automatic logic is_store(input logic [DEF_OPC_W-1:0] opc);
      return (opc == OPC_R_ST) || (opc == OPC_I_STi) || (opc == OPC_IS_STis);
   endfunction

   function automatic logic is_mem(input logic [DEF_OPC_W-1:0] opc);
      return (opc == OPC_R_LD) || is_store(opc);
   endfunction

endpackage

// File: rtl/stg4ma_rr_ptr.sv
// Round-robin port pointer: counts modulo NPORT, stepping once per advance pulse.
module stg4ma_rr_ptr #(
   parameter int NPORT = 2,
   parameter int MP_W  = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            adv_i,
   output logic [MP_W-1:0] ptr_o
);

   logic [MP_W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (adv_i) begin
         if (ptr_q == MP_W'(NPORT - 1)) ptr_d = '0;
         else                           ptr_d = ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/stg4ma_np.sv
// Memory-access pipeline stage with NPORT round-robin memory ports and valid/ready flow.
// Optional feature: define STG4MA_TIMEOUT_EN to abort an unacknowledged request after TIMEOUT cycles.
module stg4ma_np
   import stg4ma_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int OPC_W    = DEF_OPC_W,
   parameter int TGT_GP_W = DEF_TGT_GP_W,
   parameter int TGT_SR_W = DEF_TGT_SR_W,
   parameter int NPORT    = 2,
   parameter int TIMEOUT  = 15,
   localparam int MP_W    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
   input  logic                    iw_clk,
   input  logic                    iw_rst,
   input  logic                    iw_valid,
   output logic                    ow_ready,
   input  logic [ADDR_W-1:0]       iw_pc,
   input  logic [DATA_W-1:0]       iw_instr,
   input  logic [OPC_W-1:0]        iw_opc,
   input  logic [TGT_GP_W-1:0]     iw_tgt_gp,
   input  logic                    iw_tgt_gp_we,
   input  logic [TGT_SR_W-1:0]     iw_tgt_sr,
   input  logic                    iw_tgt_sr_we,
   input  logic [ADDR_W-1:0]       iw_addr,
   input  logic [DATA_W-1:0]       iw_result,
   output logic [NPORT-1:0]        ow_mem_req,
   output logic                    ow_mem_we,
   output logic [NPORT*ADDR_W-1:0] ow_mem_addr,
   output logic [DATA_W-1:0]       ow_mem_wdata,
   input  logic [NPORT-1:0]        iw_mem_ack,
   input  logic [NPORT*DATA_W-1:0] iw_mem_rdata,
   output logic                    ow_valid,
   input  logic                    iw_ready,
   output logic [ADDR_W-1:0]       ow_pc,
   output logic [DATA_W-1:0]       ow_instr,
   output logic [OPC_W-1:0]        ow_opc,
   output logic [TGT_GP_W-1:0]     ow_tgt_gp,
   output logic                    ow_tgt_gp_we,
   output logic [TGT_SR_W-1:0]     ow_tgt_sr,
   output logic                    ow_tgt_sr_we,
   output logic [DATA_W-1:0]       ow_result,
   output logic [MP_W-1:0]         ow_mem_mp,
   output logic                    ow_err
);

   stg4ma_state_e         state_q, state_d;
   logic [NPORT-1:0]      req_q, req_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  we_q, we_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic                  valid_q, valid_d;
   logic [ADDR_W-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]     instr_q, instr_d;
   logic [OPC_W-1:0]      opc_q, opc_d;
   logic [TGT_GP_W-1:0]   tgtGp_q, tgtGp_d;
   logic                  tgtGpWe_q, tgtGpWe_d;
   logic [TGT_SR_W-1:0]   tgtSr_q, tgtSr_d;
   logic                  tgtSrWe_q, tgtSrWe_d;
   logic [DATA_W-1:0]     result_q, result_d;
   logic [MP_W-1:0]       mp_q, mp_d;
   logic                  err_q, err_d;

   logic                  accept;
   logic                  memOp;
   logic                  storeOp;
   logic                  ackSel;
   logic [DATA_W-1:0]     rdataSel;
   logic                  timeoutHit;
   logic [MP_W-1:0]       rPtr;

   assign ow_ready = (state_q == ST_IDLE) && (!valid_q || iw_ready);
   assign accept   = iw_valid && ow_ready;
   assign memOp    = is_mem(DEF_OPC_W'(iw_opc));
   assign storeOp  = is_store(DEF_OPC_W'(iw_opc));

   stg4ma_rr_ptr #(
      .NPORT (NPORT),
      .MP_W  (MP_W)
   ) u_rr_ptr (
      .clk_i (iw_clk),
      .rst_i (iw_rst),
      .adv_i (accept && memOp),
      .ptr_o (rPtr)
   );

`ifdef STG4MA_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeoutHit = (cnt_q == CNT_W'(TIMEOUT));

   // Watchdog restarts on every issued request and counts only while waiting.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE)  cnt_d = '0;
      else if (!timeoutHit)    cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge iw_clk) begin
      if (iw_rst) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   logic unusedTimeout;
   assign unusedTimeout = (TIMEOUT != 0);
   assign timeoutHit    = 1'b0;
`endif

   // Only the ack and read data of the port that owns the outstanding request matter.
   always_comb begin
      ackSel   = 1'b0;
      rdataSel = '0;
      for (int p = 0; p < NPORT; p++) begin
         if (mp_q == MP_W'(p)) begin
            ackSel   = iw_mem_ack[p];
            rdataSel = iw_mem_rdata[p*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      ow_mem_addr = '0;
      for (int p = 0; p < NPORT; p++) begin
         if (req_q[p]) ow_mem_addr[p*ADDR_W +: ADDR_W] = addr_q;
      end
   end

   // Context is latched straight into the output bundle; ow_valid stays low until it is complete.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      valid_d   = valid_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      opc_d     = opc_q;
      tgtGp_d   = tgtGp_q;
      tgtGpWe_d = tgtGpWe_q;
      tgtSr_d   = tgtSr_q;
      tgtSrWe_d = tgtSrWe_q;
      result_d  = result_q;
      mp_d      = mp_q;
      err_d     = err_q;

      if (valid_q && iw_ready) begin
         valid_d = 1'b0;
         err_d   = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               pc_d      = iw_pc;
               instr_d   = iw_instr;
               opc_d     = iw_opc;
               tgtGp_d   = iw_tgt_gp;
               tgtGpWe_d = iw_tgt_gp_we;
               tgtSr_d   = iw_tgt_sr;
               tgtSrWe_d = iw_tgt_sr_we;
               result_d  = iw_result;
               err_d     = 1'b0;
               if (memOp) begin
                  state_d     = ST_WAIT;
                  req_d       = '0;
                  req_d[rPtr] = 1'b1;
                  addr_d      = iw_addr;
                  we_d        = storeOp;
                  wdata_d     = iw_result;
                  mp_d        = rPtr;
               end else begin
                  valid_d = 1'b1;
                  mp_d    = '0;
               end
            end
         end
         ST_WAIT: begin
            if (ackSel) begin
               state_d  = ST_IDLE;
               req_d    = '0;
               we_d     = 1'b0;
               valid_d  = 1'b1;
               result_d = we_q ? result_q : rdataSel;
            end else if (timeoutHit) begin
               state_d  = ST_IDLE;
               req_d    = '0;
               we_d     = 1'b0;
               valid_d  = 1'b1;
               result_d = '0;
               err_d    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         valid_q   <= 1'b0;
         pc_q      <= '0;
         instr_q   <= '0;
         opc_q     <= '0;
         tgtGp_q   <= '0;
         tgtGpWe_q <= 1'b0;
         tgtSr_q   <= '0;
         tgtSrWe_q <= 1'b0;
         result_q  <= '0;
         mp_q      <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         opc_q     <= opc_d;
         tgtGp_q   <= tgtGp_d;
         tgtGpWe_q <= tgtGpWe_d;
         tgtSr_q   <= tgtSr_d;
         tgtSrWe_q <= tgtSrWe_d;
         result_q  <= result_d;
         mp_q      <= mp_d;
         err_q     <= err_d;
      end
   end

   assign ow_mem_req   = req_q;
   assign ow_mem_we    = we_q;
   assign ow_mem_wdata = wdata_q;
   assign ow_valid     = valid_q;
   assign ow_pc        = pc_q;
   assign ow_instr     = instr_q;
   assign ow_opc       = opc_q;
   assign ow_tgt_gp    = tgtGp_q;
   assign ow_tgt_gp_we = tgtGpWe_q;
   assign ow_tgt_sr    = tgtSr_q;
   assign ow_tgt_sr_we = tgtSrWe_q;
   assign ow_result    = result_q;
   assign ow_mem_mp    = mp_q;
   assign ow_err       = err_q;

endmodule

// File: tb/tb_stg4ma_np.sv
// Directed self-checking bench for stg4ma_np (NPORT=2, 24-bit data/address).
module tb_stg4ma_np;
   import stg4ma_pkg::*;

   localparam logic [7:0] OPC_ALU = 8'h20;

   logic        clk;
   logic        rst;
   logic        iValid;
   logic        oReady;
   logic [23:0] iPc, iInstr, iAddr, iResult;
   logic [7:0]  iOpc;
   logic [3:0]  iTgtGp;
   logic        iTgtGpWe;
   logic [1:0]  iTgtSr;
   logic        iTgtSrWe;
   logic [1:0]  oMemReq;
   logic        oMemWe;
   logic [47:0] oMemAddr;
   logic [23:0] oMemWdata;
   logic [1:0]  iMemAck;
   logic [47:0] iMemRdata;
   logic        oValid;
   logic        iReady;
   logic [23:0] oPc, oInstr, oResult;
   logic [7:0]  oOpc;
   logic [3:0]  oTgtGp;
   logic        oTgtGpWe;
   logic [1:0]  oTgtSr;
   logic        oTgtSrWe;
   logic [0:0]  oMemMp;
   logic        oErr;

   int vectors;
   int miscompares;

   stg4ma_np dut (
      .iw_clk       (clk),
      .iw_rst       (rst),
      .iw_valid     (iValid),
      .ow_ready     (oReady),
      .iw_pc        (iPc),
      .iw_instr     (iInstr),
      .iw_opc       (iOpc),
      .iw_tgt_gp    (iTgtGp),
      .iw_tgt_gp_we (iTgtGpWe),
      .iw_tgt_sr    (iTgtSr),
      .iw_tgt_sr_we (iTgtSrWe),
      .iw_addr      (iAddr),
      .iw_result    (iResult),
      .ow_mem_req   (oMemReq),
      .ow_mem_we    (oMemWe),
      .ow_mem_addr  (oMemAddr),
      .ow_mem_wdata (oMemWdata),
      .iw_mem_ack   (iMemAck),
      .iw_mem_rdata (iMemRdata),
      .ow_valid     (oValid),
      .iw_ready     (iReady),
      .ow_pc        (oPc),
      .ow_instr     (oInstr),
      .ow_opc       (oOpc),
      .ow_tgt_gp    (oTgtGp),
      .ow_tgt_gp_we (oTgtGpWe),
      .ow_tgt_sr    (oTgtSr),
      .ow_tgt_sr_we (oTgtSrWe),
      .ow_result    (oResult),
      .ow_mem_mp    (oMemMp),
      .ow_err       (oErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [7:0] opc, input logic [23:0] addr,
                           input logic [23:0] result, input logic [23:0] pc);
      iValid   = 1'b1;
      iOpc     = opc;
      iAddr    = addr;
      iResult  = result;
      iPc      = pc;
      iInstr   = {opc, 16'h0000};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vectors++;
      if (oValid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %0h want 0", oValid); end
      vectors++;
      if (oMemReq !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_req: got %0h want 0", oMemReq); end
      vectors++;
      if (oResult !== 24'h0 || oPc !== 24'h0 || oErr !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_bundle: result %0h pc %0h err %0h want 0", oResult, oPc, oErr);
      end
      vectors++;
      if (oReady !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %0h want 1", oReady); end
   endtask

   task automatic test_nonmem();
      iReady = 1'b1;
      iTgtGp = 4'h5; iTgtGpWe = 1'b1;
      drive_op(OPC_ALU, 24'h0, 24'h00ABCD, 24'h000010);
      tick();
      iValid = 1'b0;
      vectors++;
      if (oValid !== 1'b1 || oResult !== 24'h00ABCD) begin
         miscompares++; $display("[TB] FAIL nonmem_out: valid %0h result %0h want 1 00abcd", oValid, oResult);
      end
      vectors++;
      if (oMemReq !== 2'b00 || oPc !== 24'h000010 || oTgtGp !== 4'h5 || oTgtGpWe !== 1'b1) begin
         miscompares++; $display("[TB] FAIL nonmem_ctx: req %0h pc %0h gp %0h we %0h want 0 10 5 1", oMemReq, oPc, oTgtGp, oTgtGpWe);
      end
      tick();
      vectors++;
      if (oValid !== 1'b0) begin miscompares++; $display("[TB] FAIL nonmem_drain: valid %0h want 0", oValid); end
   endtask

   task automatic test_loads();
      iMemRdata = {24'hBB0002, 24'hAA0001};
      iTgtGp = 4'h3;
      drive_op(OPC_R_LD, 24'h000100, 24'h777777, 24'h000040);
      tick();
      iValid = 1'b0;
      vectors++;
      if (oMemReq !== 2'b01 || oMemAddr !== 48'h000000_000100 || oMemWe !== 1'b0) begin
         miscompares++; $display("[TB] FAIL ld0_req: req %0h addr %0h we %0h want 1 000000000100 0", oMemReq, oMemAddr, oMemWe);
      end
      vectors++;
      if (oReady !== 1'b0 || oValid !== 1'b0) begin
         miscompares++; $display("[TB] FAIL ld0_wait: ready %0h valid %0h want 0 0", oReady, oValid);
      end
      tick();
      tick();
      vectors++;
      if (oMemReq !== 2'b01 || oValid !== 1'b0) begin
         miscompares++; $display("[TB] FAIL ld0_hold: req %0h valid %0h want 1 0", oMemReq, oValid);
      end
      iMemAck = 2'b01;
      tick();
      iMemAck = 2'b00;
      vectors++;
      if (oValid !== 1'b1 || oResult !== 24'hAA0001 || oMemMp !== 1'b0 || oMemReq !== 2'b00) begin
         miscompares++; $display("[TB] FAIL ld0_done: valid %0h result %0h mp %0h req %0h want 1 aa0001 0 0", oValid, oResult, oMemMp, oMemReq);
      end
      vectors++;
      if (oPc !== 24'h000040 || oTgtGp !== 4'h3 || oOpc !== OPC_R_LD) begin
         miscompares++; $display("[TB] FAIL ld0_ctx: pc %0h gp %0h opc %0h want 40 3 10", oPc, oTgtGp, oOpc);
      end
      drive_op(OPC_R_LD, 24'h000200, 24'h777777, 24'h000044);
      tick();
      iValid = 1'b0;
      vectors++;
      if (oMemReq !== 2'b10 || oMemAddr !== 48'h000200_000000 || oValid !== 1'b0) begin
         miscompares++; $display("[TB] FAIL ld1_req: req %0h addr %0h valid %0h want 2 000200000000 0", oMemReq, oMemAddr, oValid);
      end
      tick();
      tick();
      iMemAck = 2'b10;
      tick();
      iMemAck = 2'b00;
      vectors++;
      if (oValid !== 1'b1 || oResult !== 24'hBB0002 || oMemMp !== 1'b1 || oPc !== 24'h000044) begin
         miscompares++; $display("[TB] FAIL ld1_done: valid %0h result %0h mp %0h pc %0h want 1 bb0002 1 44", oValid, oResult, oMemMp, oPc);
      end
      tick();
   endtask

   task automatic test_store_wrong_ack();
      drive_op(OPC_R_ST, 24'h000300, 24'h123456, 24'h000048);
      tick();
      iValid = 1'b0;
      vectors++;
      if (oMemReq !== 2'b01 || oMemWe !== 1'b1 || oMemWdata !== 24'h123456 || oMemAddr !== 48'h000000_000300) begin
         miscompares++; $display("[TB] FAIL st_req: req %0h we %0h wdata %0h addr %0h want 1 1 123456 000000000300", oMemReq, oMemWe, oMemWdata, oMemAddr);
      end
      iMemAck = 2'b10;
      tick();
      iMemAck = 2'b00;
      vectors++;
      if (oValid !== 1'b0 || oMemReq !== 2'b01 || oMemWe !== 1'b1) begin
         miscompares++; $display("[TB] FAIL st_wrong_ack: valid %0h req %0h we %0h want 0 1 1", oValid, oMemReq, oMemWe);
      end
      tick();
      vectors++;
      if (oMemWe !== 1'b1 || oMemWdata !== 24'h123456) begin
         miscompares++; $display("[TB] FAIL st_hold: we %0h wdata %0h want 1 123456", oMemWe, oMemWdata);
      end
      iMemAck = 2'b01;
      tick();
      iMemAck = 2'b00;
      vectors++;
      if (oValid !== 1'b1 || oResult !== 24'h123456 || oMemMp !== 1'b0 || oMemReq !== 2'b00) begin
         miscompares++; $display("[TB] FAIL st_done: valid %0h result %0h mp %0h req %0h want 1 123456 0 0", oValid, oResult, oMemMp, oMemReq);
      end
      tick();
   endtask

   task automatic test_stall();
      iReady = 1'b0;
      drive_op(OPC_ALU, 24'h0, 24'h0F0F0F, 24'h000050);
      tick();
      drive_op(OPC_ALU, 24'h0, 24'h111111, 24'h000054);
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (oValid !== 1'b1 || oResult !== 24'h0F0F0F || oPc !== 24'h000050 || oReady !== 1'b0) begin
            miscompares++; $display("[TB] FAIL stall_hold%0d: valid %0h result %0h pc %0h ready %0h want 1 0f0f0f 50 0", i, oValid, oResult, oPc, oReady);
         end
      end
      iReady = 1'b1;
      #1;
      vectors++;
      if (oReady !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_release_ready: got %0h want 1", oReady); end
      tick();
      iValid = 1'b0;
      vectors++;
      if (oValid !== 1'b1 || oResult !== 24'h111111 || oPc !== 24'h000054) begin
         miscompares++; $display("[TB] FAIL stall_next: valid %0h result %0h pc %0h want 1 111111 54", oValid, oResult, oPc);
      end
      tick();
      vectors++;
      if (oValid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_drain: valid %0h want 0", oValid); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] want;
      for (int i = 0; i < 4; i++) begin
         want = 24'h000100 + 24'(i);
         drive_op(OPC_ALU, 24'h0, want, 24'h000060 + 24'(4 * i));
         tick();
         vectors++;
         if (oValid !== 1'b1 || oResult !== want || oReady !== 1'b1) begin
            miscompares++; $display("[TB] FAIL b2b_%0d: valid %0h result %0h ready %0h want 1 %0h 1", i, oValid, oResult, oReady, want);
         end
      end
      iValid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_wait();
      drive_op(OPC_R_LD, 24'h000400, 24'h0, 24'h000070);
      tick();
      iValid = 1'b0;
      vectors++;
      if (oMemReq !== 2'b10) begin miscompares++; $display("[TB] FAIL rstw_req: got %0h want 2", oMemReq); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (oMemReq !== 2'b00 || oValid !== 1'b0 || oReady !== 1'b1 || oMemAddr !== 48'h0) begin
         miscompares++; $display("[TB] FAIL rstw_clear: req %0h valid %0h ready %0h addr %0h want 0 0 1 0", oMemReq, oValid, oReady, oMemAddr);
      end
      iMemAck = 2'b10;
      tick();
      iMemAck = 2'b00;
      vectors++;
      if (oValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstw_stray_ack: valid %0h want 0", oValid); end
      drive_op(OPC_R_LD, 24'h000500, 24'h0, 24'h000074);
      tick();
      iValid  = 1'b0;
      vectors++;
      if (oMemReq !== 2'b01) begin miscompares++; $display("[TB] FAIL rstw_ptr: req %0h want 1", oMemReq); end
      iMemAck = 2'b01;
      tick();
      iMemAck = 2'b00;
      vectors++;
      if (oValid !== 1'b1 || oResult !== 24'hAA0001 || oMemMp !== 1'b0) begin
         miscompares++; $display("[TB] FAIL rstw_fast_ack: valid %0h result %0h mp %0h want 1 aa0001 0", oValid, oResult, oMemMp);
      end
      tick();
   endtask

   task automatic test_timeout();
      drive_op(OPC_R_LD, 24'h000600, 24'h555555, 24'h000080);
      tick();
      iValid = 1'b0;
      vectors++;
      if (oMemReq !== 2'b10 || oErr !== 1'b0) begin
         miscompares++; $display("[TB] FAIL to_req: req %0h err %0h want 2 0", oMemReq, oErr);
      end
`ifdef STG4MA_TIMEOUT_EN
      for (int k = 1; k <= 16; k++) begin
         tick();
         vectors++;
         if (k < 16) begin
            if (oValid !== 1'b0 || oMemReq !== 2'b10) begin
               miscompares++; $display("[TB] FAIL to_early%0d: valid %0h req %0h want 0 2", k, oValid, oMemReq);
            end
         end else if (oValid !== 1'b1 || oErr !== 1'b1 || oResult !== 24'h0 || oMemReq !== 2'b00) begin
            miscompares++; $display("[TB] FAIL to_fire: valid %0h err %0h result %0h req %0h want 1 1 0 0", oValid, oErr, oResult, oMemReq);
         end
      end
      tick();
      vectors++;
      if (oValid !== 1'b0 || oErr !== 1'b0) begin
         miscompares++; $display("[TB] FAIL to_clear: valid %0h err %0h want 0 0", oValid, oErr);
      end
`else
      for (int k = 1; k <= 20; k++) tick();
      vectors++;
      if (oValid !== 1'b0 || oMemReq !== 2'b10 || oErr !== 1'b0) begin
         miscompares++; $display("[TB] FAIL to_unbounded: valid %0h req %0h err %0h want 0 2 0", oValid, oMemReq, oErr);
      end
      iMemAck = 2'b10;
      tick();
      iMemAck = 2'b00;
      vectors++;
      if (oValid !== 1'b1 || oResult !== 24'hBB0002 || oErr !== 1'b0) begin
         miscompares++; $display("[TB] FAIL to_late_ack: valid %0h result %0h err %0h want 1 bb0002 0", oValid, oResult, oErr);
      end
      tick();
`endif
   endtask

   // Tests run in order and share the port pointer history, so their order matters.
   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      iValid      = 1'b0;
      iPc         = '0;
      iInstr      = '0;
      iOpc        = '0;
      iTgtGp      = '0;
      iTgtGpWe    = 1'b0;
      iTgtSr      = 2'b01;
      iTgtSrWe    = 1'b0;
      iAddr       = '0;
      iResult     = '0;
      iMemAck     = '0;
      iMemRdata   = {24'hBB0002, 24'hAA0001};
      iReady      = 1'b1;
      test_reset();
      test_nonmem();
      test_loads();
      test_store_wrong_ack();
      test_stall();
      test_back_to_back();
      test_reset_mid_wait();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
